// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-packet controller.
// Header byte layout: bit 7 = rw, bits 6:0 reserved (zero).
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_RSP  = 3'd4
   } state_t;

   localparam int         HDR_RW_BIT = 7;
   localparam logic [6:0] HDR_RSVD   = 7'b0;

   localparam logic CMD_WRITE = 1'b1;
   localparam logic CMD_READ  = 1'b0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] make_hdr(input logic rw);
      logic [7:0] h;
      h             = '0;
      h[6:0]        = HDR_RSVD;
      h[HDR_RW_BIT] = rw;
      return h;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the controller (slave) and its surroundings (master):
// host command port, UART TX byte port, UART RX byte strobe and read response.
interface uart_cmd_ctrl_if #(
   parameter int ADDR_BYTES = 1,
   parameter int DATA_BYTES = 1
);
   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // the producer holds its payload stable while valid && !ready. rx_valid,
   // rsp_valid, wr_done and rx_drop are single-cycle strobes with no ready.
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_rw;
   logic [8*ADDR_BYTES-1:0] cmd_addr;
   logic [8*DATA_BYTES-1:0] cmd_wdata;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic                    wr_done;
   logic [8*DATA_BYTES-1:0] rsp_data;
   logic                    rsp_valid;
   logic                    rsp_err;
   logic                    rx_drop;

   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, tx_ready, rx_data, rx_valid,
      input  cmd_ready, tx_data, tx_valid, wr_done, rsp_data, rsp_valid, rsp_err, rx_drop
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, tx_ready, rx_data, rx_valid,
      output cmd_ready, tx_data, tx_valid, wr_done, rsp_data, rsp_valid, rsp_err, rx_drop
   );

endinterface

// File: rtl/uart_cmd_shift.sv
// Byte-wide shift register: parallel load and MSB-first shift-out for TX,
// shift-in at the LSB for RX (first byte received ends up in the MSB).
module uart_cmd_shift #(
   parameter int NB = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [8*NB-1:0] load_data,
   input  logic            shift_out,
   input  logic            shift_in,
   input  logic [7:0]      in_byte,
   output logic [8*NB-1:0] data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift_out) begin
         data <= data << 8;
      end else if (shift_in) begin
         data <= (data << 8) | (8*NB)'(in_byte);
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-packet controller: header + address (+ write data) out over UART TX,
// read response bytes collected from UART RX. Read timeout via UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int ADDR_BYTES     = 1,
   parameter int DATA_BYTES     = 1,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic      clk,
   input  logic      rst,
   uart_cmd_ctrl_if.slave bus,
   output state_t    state_dbg
);

   localparam int MAXB = max2(ADDR_BYTES, DATA_BYTES);
   localparam int CW   = $clog2(MAXB) + 1;
   localparam int TW   = 8 * MAXB;
   localparam int DW   = 8 * DATA_BYTES;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            rw_q;
   logic [DW-1:0]   wdata_q;
   logic [TW-1:0]   tx_word;
   logic [DW-1:0]   rx_word;
   logic [DW-1:0]   rx_next;
   logic [7:0]      tx_top;
   logic            tx_hs;
   logic            sh_load;
   logic [TW-1:0]   sh_load_data;
   logic            sh_shift;
   logic            rx_shift;

   assign state_dbg = state;
   assign tx_hs     = bus.tx_valid && bus.tx_ready;
   assign tx_top    = tx_word[TW-1 -: 8];
   assign rx_shift  = (state == ST_RSP) && bus.rx_valid;
   assign rx_next   = (rx_word << 8) | DW'(bus.rx_data);

   // tx_data always holds the byte on offer; the TX shifter holds the bytes
   // still to come, left-aligned so its top byte is always the next one.
   always_comb begin
      sh_load      = 1'b0;
      sh_load_data = '0;
      sh_shift     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               sh_load      = 1'b1;
               sh_load_data = TW'(bus.cmd_addr) << (8 * (MAXB - ADDR_BYTES));
            end
         end
         ST_HDR:  sh_shift = tx_hs;
         ST_ADDR: begin
            if (tx_hs) begin
               if (cnt == CW'(ADDR_BYTES - 1)) begin
                  if (rw_q == CMD_WRITE) begin
                     sh_load      = 1'b1;
                     sh_load_data = (TW'(wdata_q) << (8 * (MAXB - DATA_BYTES))) << 8;
                  end
               end else begin
                  sh_shift = 1'b1;
               end
            end
         end
         ST_DATA: sh_shift = tx_hs;
         default: ;
      endcase
   end

   uart_cmd_shift #(.NB(MAXB)) u_tx_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (sh_load),
      .load_data (sh_load_data),
      .shift_out (sh_shift),
      .shift_in  (1'b0),
      .in_byte   (8'h00),
      .data      (tx_word)
   );

   uart_cmd_shift #(.NB(DATA_BYTES)) u_rx_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (1'b0),
      .load_data ({DW{1'b0}}),
      .shift_out (1'b0),
      .shift_in  (rx_shift),
      .in_byte   (bus.rx_data),
      .data      (rx_word)
   );

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TMW-1:0] tmo;
`else
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         rw_q          <= CMD_READ;
         wdata_q       <= '0;
         bus.cmd_ready <= 1'b1;
         bus.tx_valid  <= 1'b0;
         bus.tx_data   <= 8'h00;
         bus.wr_done   <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rx_drop   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
         bus.rsp_err   <= 1'b0;
         tmo           <= '0;
`endif
      end else begin
         bus.wr_done   <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rx_drop   <= bus.rx_valid && (state != ST_RSP);
         case (state)
            ST_IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  rw_q          <= bus.cmd_rw;
                  wdata_q       <= bus.cmd_wdata;
                  cnt           <= '0;
                  bus.cmd_ready <= 1'b0;
                  bus.tx_valid  <= 1'b1;
                  bus.tx_data   <= make_hdr(bus.cmd_rw);
                  state         <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (tx_hs) begin
                  bus.tx_data <= tx_top;
                  cnt         <= '0;
                  state       <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (tx_hs) begin
                  if (cnt == CW'(ADDR_BYTES - 1)) begin
                     cnt <= '0;
                     if (rw_q == CMD_WRITE) begin
                        bus.tx_data <= wdata_q[DW-1 -: 8];
                        state       <= ST_DATA;
                     end else begin
                        bus.tx_valid <= 1'b0;
                        bus.tx_data  <= 8'h00;
                        state        <= ST_RSP;
`ifdef UART_CMD_TIMEOUT_EN
                        tmo          <= '0;
`endif
                     end
                  end else begin
                     bus.tx_data <= tx_top;
                     cnt         <= cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tx_hs) begin
                  if (cnt == CW'(DATA_BYTES - 1)) begin
                     bus.tx_valid  <= 1'b0;
                     bus.tx_data   <= 8'h00;
                     bus.wr_done   <= 1'b1;
                     bus.cmd_ready <= 1'b1;
                     cnt           <= '0;
                     state         <= ST_IDLE;
                  end else begin
                     bus.tx_data <= tx_top;
                     cnt         <= cnt + 1'b1;
                  end
               end
            end
            ST_RSP: begin
               // A final byte arriving on the expiry cycle still completes cleanly.
               if (bus.rx_valid && (cnt == CW'(DATA_BYTES - 1))) begin
                  bus.rsp_data  <= rx_next;
                  bus.rsp_valid <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  cnt           <= '0;
                  state         <= ST_IDLE;
`ifdef UART_CMD_TIMEOUT_EN
                  bus.rsp_err   <= 1'b0;
               end else if (tmo == TMW'(TIMEOUT_CYCLES - 1)) begin
                  bus.rsp_data  <= '0;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  cnt           <= '0;
                  state         <= ST_IDLE;
`endif
               end else begin
                  if (bus.rx_valid) cnt <= cnt + 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
                  tmo <= tmo + 1'b1;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with ADDR_BYTES=1, DATA_BYTES=2; the timeout
// case is compiled only when UART_CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=100).
module tb_uart_cmd_ctrl;
   import uart_cmd_pkg::*;

   localparam int AB = 1;
   localparam int DB = 2;
`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 5_000_000;
`endif

   // clock / reset
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t state_dbg;

   always #5 clk = ~clk;

   uart_cmd_ctrl_if #(.ADDR_BYTES(AB), .DATA_BYTES(DB)) bus ();

   uart_cmd_ctrl #(
      .ADDR_BYTES     (AB),
      .DATA_BYTES     (DB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         mon_en = 1'b0;
   logic [7:0] prev_data = 8'h00;
   bit         prev_stall = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic rw, input logic [7:0] addr, input logic [15:0] wdata);
      check("cmd_ready_pre", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_rw    = rw;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = 16'h0000;
   endtask

   // scoreboard: every accepted TX byte is matched against exp_q in order
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            check("stall_valid", bus.tx_valid, 1);
            check("stall_hold", bus.tx_data, prev_data);
         end
         if (bus.tx_valid && bus.tx_ready) begin
            check("byte_avail", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("tx_byte", bus.tx_data, exp_q.pop_front());
         end
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int k;
      bus.cmd_valid = 1'b0;
      bus.cmd_rw    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.tx_ready  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;

      // reset state
      repeat (3) tick();
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_wr_done", bus.wr_done, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rx_drop", bus.rx_drop, 0);
      check("rst_state", state_dbg, ST_IDLE);
      rst = 1'b0;
      tick();

      // write 0x5A <- 0xBEEF, tx_ready held high
      bus.tx_ready = 1'b1;
      start_cmd(1'b1, 8'h5A, 16'hBEEF);
      check("wr_hdr_valid", bus.tx_valid, 1);
      check("wr_hdr", bus.tx_data, 8'h80);
      check("wr_busy", bus.cmd_ready, 0);
      tick();
      check("wr_addr", bus.tx_data, 8'h5A);
      tick();
      check("wr_d0", bus.tx_data, 8'hBE);
      tick();
      check("wr_d1", bus.tx_data, 8'hEF);
      check("wr_done_early", bus.wr_done, 0);
      tick();
      check("wr_done", bus.wr_done, 1);
      check("wr_idle_ready", bus.cmd_ready, 1);
      check("wr_tx_off", bus.tx_valid, 0);
      tick();
      check("wr_done_pulse", bus.wr_done, 0);

      // read 0x5A, response 0x12, 0x34
      start_cmd(1'b0, 8'h5A, 16'h0000);
      check("rd_hdr", bus.tx_data, 8'h00);
      check("rd_hdr_valid", bus.tx_valid, 1);
      tick();
      check("rd_addr", bus.tx_data, 8'h5A);
      tick();
      check("rd_tx_off", bus.tx_valid, 0);
      check("rd_state", state_dbg, ST_RSP);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h12;
      tick();
      bus.rx_valid = 1'b0;
      check("rd_partial", bus.rsp_valid, 0);
      tick();
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h34;
      tick();
      bus.rx_valid = 1'b0;
      check("rd_rsp_valid", bus.rsp_valid, 1);
      check("rd_rsp_data", bus.rsp_data, 16'h1234);
      check("rd_rsp_err", bus.rsp_err, 0);
      check("rd_idle_ready", bus.cmd_ready, 1);
      tick();
      check("rd_rsp_pulse", bus.rsp_valid, 0);
      check("rd_rsp_hold", bus.rsp_data, 16'h1234);

      // stray rx byte while idle
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h77;
      tick();
      bus.rx_valid = 1'b0;
      check("drop_pulse", bus.rx_drop, 1);
      check("drop_no_rsp", bus.rsp_valid, 0);
      tick();
      check("drop_clear", bus.rx_drop, 0);
      check("drop_rsp_hold", bus.rsp_data, 16'h1234);

      // write with tx_ready toggling every cycle
      exp_q.push_back(8'h80);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'h13);
      exp_q.push_back(8'h57);
      mon_en       = 1'b1;
      bus.tx_ready = 1'b0;
      start_cmd(1'b1, 8'hC3, 16'h1357);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.tx_ready = ~bus.tx_ready;
         tick();
         if (bus.wr_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("stall_wr_done", seen, 1);
      check("stall_all_bytes", exp_q.size(), 0);
      mon_en       = 1'b0;
      bus.tx_ready = 1'b1;
      tick();

      // reset after the address byte of a write, then a clean read
      start_cmd(1'b1, 8'h5A, 16'hBEEF);
      tick();
      tick();
      check("abort_pre_state", state_dbg, ST_DATA);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_tx_off", bus.tx_valid, 0);
      check("abort_ready", bus.cmd_ready, 1);
      check("abort_state", state_dbg, ST_IDLE);
      check("abort_no_done", bus.wr_done, 0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h21);
      mon_en = 1'b1;
      start_cmd(1'b0, 8'h21, 16'h0000);
      tick();
      tick();
      check("abort_rd_state", state_dbg, ST_RSP);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hAB;
      tick();
      bus.rx_data  = 8'hCD;
      tick();
      bus.rx_valid = 1'b0;
      check("abort_rd_valid", bus.rsp_valid, 1);
      check("abort_rd_data", bus.rsp_data, 16'hABCD);
      check("abort_rd_bytes", exp_q.size(), 0);
      mon_en = 1'b0;
      tick();

`ifdef UART_CMD_TIMEOUT_EN
      // read with only one response byte: times out 100 cycles after RSP entry
      start_cmd(1'b0, 8'h40, 16'h0000);
      tick();
      tick();
      check("tmo_state", state_dbg, ST_RSP);
      k = 0;
      for (int i = 0; i < 200; i++) begin
         bus.rx_valid = (i == 5);
         bus.rx_data  = 8'h99;
         tick();
         k = i + 1;
         if (bus.rsp_valid) break;
      end
      bus.rx_valid = 1'b0;
      check("tmo_cycles", k, 100);
      check("tmo_valid", bus.rsp_valid, 1);
      check("tmo_err", bus.rsp_err, 1);
      check("tmo_data", bus.rsp_data, 0);
      check("tmo_ready", bus.cmd_ready, 1);
      tick();
      check("tmo_pulse", bus.rsp_valid, 0);
`endif

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
